// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller_pkg
// Description : Shared types and default constants for the pipeline
//               stall/flush sequencer.
//               - state_t : memory-wait FSM encoding
//               - ctrl_t  : per-stage hold/bubble/flush control bundle
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_stall_controller_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int DEFAULT_CNT_W   = 32;

  // Full freeze used while a data-memory access is in flight: every
  // upstream register holds and MEM_WB receives a NOP.
  localparam ctrl_t C_FREEZE = '{
    pc_stall      : 1'b1,
    if_id_stall   : 1'b1,
    if_id_flush   : 1'b0,
    id_ex_bubble  : 1'b0,
    id_ex_stall   : 1'b1,
    ex_mem_stall  : 1'b1,
    mem_wb_bubble : 1'b1
  };

endpackage : pipeline_stall_controller_pkg
`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value.
//   i_clk   : clock
//   i_rstN  : asynchronous active-low reset
//   i_inc   : count one event this cycle
//   i_clr   : synchronous clear (wins over i_inc)
//   o_count : current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstN,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Merges load-use hazards, taken-branch redirects and
//               multi-cycle data-memory accesses into one consistent set of
//               per-stage controls. Owns the memory-wait FSM, a watchdog
//               and saturating stall/flush performance counters.
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   load_use_i              : load-use hazard from hazard detection
//   branch_taken_i          : branch in ID resolved taken
//   mem_req_i / mem_ack_i   : data-memory request from EX_MEM / completion
//   mem_start_o             : one-cycle access launch pulse
//   pc_stall_o ..           : per-stage hold / bubble / flush controls
//   mem_wb_bubble_o
//   timeout_o               : sticky watchdog error
//   stall_cnt_o/flush_cnt_o : saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             mem_start_o,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             id_ex_stall_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_bubble_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_stateNext;
  ctrl_t             w_ctrl;
  logic              w_memStart;
  logic              w_waitClr;
  logic              w_waitInc;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_waitCntNext;
  logic              r_timeout;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    w_ctrl      = '0;
    w_memStart  = 1'b0;
    w_waitClr   = 1'b0;
    w_waitInc   = 1'b0;

    case (r_state)
      RUN: begin
        if (mem_req_i) begin
          // Memory access outranks hazards: the whole pipe freezes, so any
          // pending load-use or branch is simply re-presented later.
          w_memStart  = 1'b1;
          w_ctrl      = C_FREEZE;
          w_waitClr   = 1'b1;
          w_stateNext = MEM_WAIT;
        end else if (load_use_i) begin
          // Branch held in IF_ID re-evaluates next cycle, so flushing it
          // now would lose it; only the stall acts.
          w_ctrl.pc_stall     = 1'b1;
          w_ctrl.if_id_stall  = 1'b1;
          w_ctrl.id_ex_bubble = 1'b1;
        end else if (branch_taken_i) begin
          w_ctrl.if_id_flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_ack_i) begin
          // All controls low: pipe advances and MEM_WB captures the data.
          w_stateNext = RUN;
        end else begin
          w_ctrl    = C_FREEZE;
          w_waitInc = 1'b1;
        end
      end

      default: begin
        w_stateNext = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Watchdog: counts unacknowledged MEM_WAIT cycles, saturating at TIMEOUT.
  // The error flag is sticky; the FSM keeps waiting regardless.
  // --------------------------------------------------------------------------
  assign w_waitCntNext = (r_waitCnt == C_WAIT_MAX) ? r_waitCnt : r_waitCnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_waitCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_waitClr) begin
        r_waitCnt <= '0;
      end else if (w_waitInc) begin
        r_waitCnt <= w_waitCntNext;
        if (w_waitCntNext == C_WAIT_MAX) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: gated by reset so everything reads low while rst_i is asserted,
  // independent of any combinational input activity.
  // --------------------------------------------------------------------------
  assign mem_start_o     = rst_i & w_memStart;
  assign pc_stall_o      = rst_i & w_ctrl.pc_stall;
  assign if_id_stall_o   = rst_i & w_ctrl.if_id_stall;
  assign if_id_flush_o   = rst_i & w_ctrl.if_id_flush;
  assign id_ex_bubble_o  = rst_i & w_ctrl.id_ex_bubble;
  assign id_ex_stall_o   = rst_i & w_ctrl.id_ex_stall;
  assign ex_mem_stall_o  = rst_i & w_ctrl.ex_mem_stall;
  assign mem_wb_bubble_o = rst_i & w_ctrl.mem_wb_bubble;
  assign timeout_o       = r_timeout;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(
    .W (CNT_W)
  ) u_stallCnt (
    .i_clk   (clk_i),
    .i_rstN  (rst_i),
    .i_inc   (pc_stall_o),
    .i_clr   (1'b0),
    .o_count (stall_cnt_o)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flushCnt (
    .i_clk   (clk_i),
    .i_rstN  (rst_i),
    .i_inc   (if_id_flush_o),
    .i_clr   (1'b0),
    .o_count (flush_cnt_o)
  );

  // --------------------------------------------------------------------------
  // Control invariants
  // --------------------------------------------------------------------------
  a_ifIdExclusive : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(if_id_stall_o && if_id_flush_o));

  a_idExExclusive : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(id_ex_stall_o && id_ex_bubble_o));

endmodule : pipeline_stall_controller
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Directed self-checking bench for pipeline_stall_controller.
//               Control outputs are compared as one 8-bit vector:
//               {mem_start, pc_stall, if_id_stall, if_id_flush,
//                id_ex_bubble, id_ex_stall, ex_mem_stall, mem_wb_bubble}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_CNT_W   = 3;

  localparam logic [7:0] C_IDLE   = 8'h00;
  localparam logic [7:0] C_LAUNCH = 8'hE7;
  localparam logic [7:0] C_WAIT   = 8'h67;
  localparam logic [7:0] C_LDUSE  = 8'h68;
  localparam logic [7:0] C_FLUSH  = 8'h10;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                load_use_i;
  logic                branch_taken_i;
  logic                mem_req_i;
  logic                mem_ack_i;
  logic                mem_start_o;
  logic                pc_stall_o;
  logic                if_id_stall_o;
  logic                if_id_flush_o;
  logic                id_ex_bubble_o;
  logic                id_ex_stall_o;
  logic                ex_mem_stall_o;
  logic                mem_wb_bubble_o;
  logic                timeout_o;
  logic [TB_CNT_W-1:0] stall_cnt_o;
  logic [TB_CNT_W-1:0] flush_cnt_o;

  int nChecks = 0;
  int nErrors = 0;

  logic [7:0] w_ctrlVec;
  assign w_ctrlVec = {mem_start_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
                      id_ex_bubble_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o};

  always #5 clk_i = ~clk_i;

  pipeline_stall_controller #(
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .load_use_i      (load_use_i),
    .branch_taken_i  (branch_taken_i),
    .mem_req_i       (mem_req_i),
    .mem_ack_i       (mem_ack_i),
    .mem_start_o     (mem_start_o),
    .pc_stall_o      (pc_stall_o),
    .if_id_stall_o   (if_id_stall_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_bubble_o  (id_ex_bubble_o),
    .id_ex_stall_o   (id_ex_stall_o),
    .ex_mem_stall_o  (ex_mem_stall_o),
    .mem_wb_bubble_o (mem_wb_bubble_o),
    .timeout_o       (timeout_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so new inputs are applied mid-cycle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic doReset();
    rst_i          = 1'b0;
    load_use_i     = 1'b0;
    branch_taken_i = 1'b0;
    mem_req_i      = 1'b0;
    mem_ack_i      = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    doReset();

    // Reset state and idle
    for (int i = 0; i < 5; i++) begin
      sample();
      checkVal("idle ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
      tick();
    end
    checkVal("idle stall_cnt", {29'd0, stall_cnt_o}, 32'd0);
    checkVal("idle flush_cnt", {29'd0, flush_cnt_o}, 32'd0);
    checkVal("idle timeout", {31'd0, timeout_o}, 32'd0);

    // Single load-use stall
    load_use_i = 1'b1;
    sample();
    checkVal("lduse ctrl", {24'd0, w_ctrlVec}, {24'd0, C_LDUSE});
    tick();
    load_use_i = 1'b0;
    sample();
    checkVal("lduse after ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    checkVal("lduse stall_cnt", {29'd0, stall_cnt_o}, 32'd1);

    // Load-use and branch together: stall wins, branch acts next cycle
    tick();
    load_use_i     = 1'b1;
    branch_taken_i = 1'b1;
    sample();
    checkVal("lduse+br ctrl", {24'd0, w_ctrlVec}, {24'd0, C_LDUSE});
    tick();
    load_use_i = 1'b0;
    sample();
    checkVal("br ctrl", {24'd0, w_ctrlVec}, {24'd0, C_FLUSH});
    tick();
    branch_taken_i = 1'b0;
    sample();
    checkVal("br after ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    checkVal("br flush_cnt", {29'd0, flush_cnt_o}, 32'd1);
    checkVal("br stall_cnt", {29'd0, stall_cnt_o}, 32'd2);

    // Memory access acked after 3 wait cycles
    doReset();
    mem_req_i = 1'b1;
    sample();
    checkVal("mem launch ctrl", {24'd0, w_ctrlVec}, {24'd0, C_LAUNCH});
    tick();
    mem_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checkVal("mem wait ctrl", {24'd0, w_ctrlVec}, {24'd0, C_WAIT});
      tick();
    end
    mem_ack_i = 1'b1;
    sample();
    checkVal("mem ack ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    tick();
    mem_ack_i = 1'b0;
    sample();
    checkVal("mem after ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    checkVal("mem stall_cnt", {29'd0, stall_cnt_o}, 32'd4);
    checkVal("mem timeout", {31'd0, timeout_o}, 32'd0);

    // Watchdog: no ack for TIMEOUT wait cycles; stall counter saturates
    doReset();
    mem_req_i = 1'b1;
    sample();
    checkVal("wd launch ctrl", {24'd0, w_ctrlVec}, {24'd0, C_LAUNCH});
    tick();
    mem_req_i = 1'b0;
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      sample();
      checkVal("wd pre timeout", {31'd0, timeout_o}, 32'd0);
      checkVal("wd wait ctrl", {24'd0, w_ctrlVec}, {24'd0, C_WAIT});
      tick();
    end
    sample();
    checkVal("wd timeout set", {31'd0, timeout_o}, 32'd1);
    checkVal("wd stall_cnt sat", {29'd0, stall_cnt_o}, 32'd7);
    tick();
    tick();
    sample();
    checkVal("wd timeout sticky", {31'd0, timeout_o}, 32'd1);
    checkVal("wd still waiting", {24'd0, w_ctrlVec}, {24'd0, C_WAIT});
    tick();
    mem_ack_i = 1'b1;
    sample();
    checkVal("wd late ack ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    tick();
    mem_ack_i = 1'b0;
    sample();
    checkVal("wd run ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    checkVal("wd timeout after ack", {31'd0, timeout_o}, 32'd1);
    checkVal("wd flush_cnt", {29'd0, flush_cnt_o}, 32'd0);

    // Reset in MEM_WAIT aborts the access
    tick();
    mem_req_i = 1'b1;
    sample();
    checkVal("rst launch ctrl", {24'd0, w_ctrlVec}, {24'd0, C_LAUNCH});
    tick();
    mem_req_i = 1'b0;
    sample();
    checkVal("rst wait ctrl", {24'd0, w_ctrlVec}, {24'd0, C_WAIT});
    #1;
    rst_i = 1'b0;
    #1;
    checkVal("rst async ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    checkVal("rst async timeout", {31'd0, timeout_o}, 32'd0);
    checkVal("rst async stall_cnt", {29'd0, stall_cnt_o}, 32'd0);
    tick();
    rst_i     = 1'b1;
    mem_ack_i = 1'b1;
    sample();
    checkVal("rst stray ack ctrl", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    tick();
    mem_ack_i = 1'b0;
    mem_req_i = 1'b1;
    sample();
    checkVal("rst relaunch ctrl", {24'd0, w_ctrlVec}, {24'd0, C_LAUNCH});
    tick();
    mem_req_i = 1'b0;
    mem_ack_i = 1'b1;
    sample();
    checkVal("rst min latency ack", {24'd0, w_ctrlVec}, {24'd0, C_IDLE});
    tick();
    mem_ack_i = 1'b0;
    sample();
    checkVal("rst final stall_cnt", {29'd0, stall_cnt_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule : tb_pipeline_stall_controller
`default_nettype wire
